seg_scan_decoder: RTL and testbench
===================================

# seg_scan_decoder

Receive-side counterpart of the 8-digit multiplexed seven-segment display driver. It watches the scanned `sel`/`seg` lines, waits for each digit to settle, decodes the segment pattern back to a hex nibble, and reassembles the full 32-bit display word plus per-digit blank and decimal-point masks. It serves as a self-check monitor in the vending-machine top level: the control module compares the recovered frame against the value it sent for display, and the same block is reused as a bench scoreboard front-end.

## Interface
- `SETTLE_CYC`, 16: cycles that `sel` and `seg` must stay unchanged before a digit is captured.
- `TIMEOUT_CYC`, 2_000_000: cycles allowed to collect all 8 digits (20 ms at 100 MHz) before the partial frame is discarded.
- `clk  in  1`: 100 MHz system clock; all logic on the rising edge.
- `rst_n  in  1`: synchronous, active-low reset.
- `sel  in  8`: digit select, active-low; `sel[i]`=0 selects digit i.
- `seg  in  8`: segments, active-low; `seg[7]`=dp, `seg[6:0]`={g,f,e,d,c,b,a}.
- `disp_data  out  32`: recovered word; digit i occupies bits [4i+3:4i].
- `blank_mask  out  8`: bit i set if digit i was captured with all of seg[6:0] off.
- `dp_mask  out  8`: bit i set if digit i was captured with dp lit.
- `frame_valid  out  1`: one-cycle pulse when all 8 outputs above update together.
- `frame_err  out  1`: qualified by `frame_valid`; set if any digit in the frame failed to decode.
- `frame_timeout  out  1`: one-cycle pulse when a partial frame is discarded.

## Operation
- Input stage: `sel`/`seg` registered once (`sel_q`, `seg_q`). Change detection compares each register against its previous value.
- FSM states:
  - WAIT: stay here while `sel_q` is not exactly one-low. Go to SETTLE on a valid one-low pattern and load 0 into the settle counter.
  - SETTLE: return to WAIT if `sel_q` stops being one-low. Otherwise any change in `sel_q` or `seg_q` reloads the counter to 0 and stays in SETTLE. When the counter reaches `SETTLE_CYC-1`, capture the digit and go to HELD.
  - HELD: stay until `sel_q` changes, then go to WAIT. Each digit is captured at most once per dwell.
- Capture:
  - The decoded nibble goes into the slot for index i. `blank_i` = (~seg_q[6:0]==0) and `dp_i` = ~seg_q[7] are written at the same time. Set `seen[i]`.
  - Decode table, active-high `~seg[6:0]` → nibble: 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 6F→9, 77→A, 7C→B, 39→C, 5E→D, 79→E, 71→F.
  - Blank decodes to nibble 0 with the blank bit set. Any other pattern decodes to nibble 0 and sets `err_acc`.
- Frame complete: when `seen` becomes 8'hFF (the capture cycle included), the next cycle copies the slots into `disp_data`, `blank_mask` and `dp_mask`. It pulses `frame_valid`, drives `frame_err`=`err_acc`, and clears `seen`, `err_acc` and the timeout counter.
- Recapture of an already-seen digit in the same frame overwrites its slot without error.
- Timeout: the counter runs while `seen`≠0. At `TIMEOUT_CYC-1` it pulses `frame_timeout` and clears `seen` and `err_acc`. The outputs keep the last good frame.
- Simultaneous completion and timeout: completion wins and no timeout pulse is issued.
- Reset (any cycle, mid-frame included): FSM to WAIT, counters 0, `seen`/`err_acc` 0. `disp_data`, `blank_mask`, `dp_mask`, `frame_valid`, `frame_err` and `frame_timeout` all go to 0.

## Timing
- Capture happens `SETTLE_CYC`+1 cycles after the change reaches the `sel`/`seg` pins: 1 cycle for the input register plus `SETTLE_CYC` cycles of settling.
- `frame_valid` follows the eighth capture by 1 cycle.
- Outputs are registered and hold stable between `frame_valid` pulses.
- Settle counter width is `$clog2(SETTLE_CYC)`; timeout counter width is `$clog2(TIMEOUT_CYC)`. Both saturate and never wrap.

## Structure
- Shared package `seg7_pkg`: `NUM_DIGITS`=8, the 16 `SEG_HEX_*` active-high pattern constants, and `SEG_BLANK`. The display driver uses the same constants.
- Sub-module `seg7_pattern_decode` (combinational): 7-bit pattern in; nibble, blank and err out.
- Everything else lives in the top: FSM, counters and frame assembly.

## Test plan
- Scan 32'h1234_ABCD, each digit held 100 cycles with 20 cycles of sel=FF between digits, no dp → `frame_valid` once, `disp_data`=32'h1234ABCD, masks 0, `frame_err`=0.
- Toggle `seg` of digit 3 every 5 cycles for 40 cycles, then hold 7F → digit 3 captured as 8 exactly `SETTLE_CYC`+1 cycles after the last toggle reaches the pins.
- Digit 5 pattern 0x49 (invalid), others valid → `frame_err`=1 and nibble 5 = 0. The next clean frame gives `frame_err`=0.
- Scan only digits 0–6, then idle → `frame_timeout` pulse at `TIMEOUT_CYC`, outputs unchanged. A following full frame is decoded correctly.
- Digit 2 blank with dp lit, `sel`=8'b1111_0011 injected for 30 cycles → no capture during the two-low window; `blank_mask`=04, `dp_mask`=04.
- Assert `rst_n`=0 for 1 cycle after 4 captures → all outputs 0 and the next frame requires all 8 digits again.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared seven-segment constants and types for the scan driver and its
// receive-side decoder.
package seg7_pkg;

   localparam int NUM_DIGITS = 8;

   // Active-high segment patterns {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_HEX_0 = 7'h3F;
   localparam logic [6:0] SEG_HEX_1 = 7'h06;
   localparam logic [6:0] SEG_HEX_2 = 7'h5B;
   localparam logic [6:0] SEG_HEX_3 = 7'h4F;
   localparam logic [6:0] SEG_HEX_4 = 7'h66;
   localparam logic [6:0] SEG_HEX_5 = 7'h6D;
   localparam logic [6:0] SEG_HEX_6 = 7'h7D;
   localparam logic [6:0] SEG_HEX_7 = 7'h07;
   localparam logic [6:0] SEG_HEX_8 = 7'h7F;
   localparam logic [6:0] SEG_HEX_9 = 7'h6F;
   localparam logic [6:0] SEG_HEX_A = 7'h77;
   localparam logic [6:0] SEG_HEX_B = 7'h7C;
   localparam logic [6:0] SEG_HEX_C = 7'h39;
   localparam logic [6:0] SEG_HEX_D = 7'h5E;
   localparam logic [6:0] SEG_HEX_E = 7'h79;
   localparam logic [6:0] SEG_HEX_F = 7'h71;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   typedef enum logic [1:0] {
      ST_WAIT,
      ST_SETTLE,
      ST_HELD
   } scan_state_t;

   // Index of the selected digit; only meaningful when exactly one bit is low.
   function automatic logic [2:0] sel_index(input logic [NUM_DIGITS-1:0] sel_n);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         if (!sel_n[i]) idx = 3'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational decode of an active-high seven-segment pattern back to a
// hex nibble, flagging blank and unrecognised patterns.
module seg7_pattern_decode
   import seg7_pkg::*;
(
   input  logic [6:0] pat_i,
   output logic [3:0] nibble_o,
   output logic       blank_o,
   output logic       err_o
);

   always_comb begin
      nibble_o = 4'h0;
      blank_o  = 1'b0;
      err_o    = 1'b0;
      case (pat_i)
         SEG_HEX_0: nibble_o = 4'h0;
         SEG_HEX_1: nibble_o = 4'h1;
         SEG_HEX_2: nibble_o = 4'h2;
         SEG_HEX_3: nibble_o = 4'h3;
         SEG_HEX_4: nibble_o = 4'h4;
         SEG_HEX_5: nibble_o = 4'h5;
         SEG_HEX_6: nibble_o = 4'h6;
         SEG_HEX_7: nibble_o = 4'h7;
         SEG_HEX_8: nibble_o = 4'h8;
         SEG_HEX_9: nibble_o = 4'h9;
         SEG_HEX_A: nibble_o = 4'hA;
         SEG_HEX_B: nibble_o = 4'hB;
         SEG_HEX_C: nibble_o = 4'hC;
         SEG_HEX_D: nibble_o = 4'hD;
         SEG_HEX_E: nibble_o = 4'hE;
         SEG_HEX_F: nibble_o = 4'hF;
         SEG_BLANK: blank_o  = 1'b1;
         default:   err_o    = 1'b1;
      endcase
   end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers the 32-bit display word and blank/dp masks from a scanned,
// active-low 8-digit seven-segment bus.
//
// state  | meaning
// WAIT   | sel not exactly one-low; idle between digits
// SETTLE | one digit selected; counting cycles of unchanged sel/seg
// HELD   | digit captured; wait for sel to move on
module seg_scan_decoder
   import seg7_pkg::*;
#(
   parameter int SETTLE_CYC  = 16,
   parameter int TIMEOUT_CYC = 2_000_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  sel,
   input  logic [7:0]  seg,
   output logic [31:0] disp_data,
   output logic [7:0]  blank_mask,
   output logic [7:0]  dp_mask,
   output logic        frame_valid,
   output logic        frame_err,
   output logic        frame_timeout
);

   localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   logic [7:0]    sel_q, seg_q, sel_prev_q, seg_prev_q;
   scan_state_t   state_q, state_d;
   logic [SW-1:0] scnt_q, scnt_d;
   logic [TW-1:0] tcnt_q, tcnt_d;
   logic [31:0]   slot_nib_q;
   logic [7:0]    slot_blank_q, slot_dp_q;
   logic [7:0]    seen_q, seen_d;
   logic          err_acc_q, err_acc_d;
   logic [31:0]   disp_data_q;
   logic [7:0]    blank_mask_q, dp_mask_q;
   logic          frame_valid_q, frame_err_q, frame_timeout_q;

   logic          one_low, sel_chg, any_chg, settled, capture;
   logic          complete, timeout_hit;
   logic [2:0]    dig_idx;
   logic [3:0]    dec_nib;
   logic          dec_blank, dec_err;

   assign one_low = $onehot(~sel_q);
   assign sel_chg = (sel_q != sel_prev_q);
   assign any_chg = sel_chg || (seg_q != seg_prev_q);
   assign settled = (scnt_q == SW'(SETTLE_CYC - 1));
   assign dig_idx = sel_index(sel_q);

   seg7_pattern_decode u_decode (
      .pat_i    (~seg_q[6:0]),
      .nibble_o (dec_nib),
      .blank_o  (dec_blank),
      .err_o    (dec_err)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sel_q      <= 8'hFF;
         seg_q      <= 8'hFF;
         sel_prev_q <= 8'hFF;
         seg_prev_q <= 8'hFF;
         state_q    <= ST_WAIT;
         scnt_q     <= '0;
      end else begin
         sel_q      <= sel;
         seg_q      <= seg;
         sel_prev_q <= sel_q;
         seg_prev_q <= seg_q;
         state_q    <= state_d;
         scnt_q     <= scnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_WAIT:   if (one_low) state_d = ST_SETTLE;
         ST_SETTLE: begin
            if (!one_low)                 state_d = ST_WAIT;
            else if (!any_chg && settled) state_d = ST_HELD;
         end
         ST_HELD:   if (sel_chg) state_d = ST_WAIT;
         default:   state_d = ST_WAIT;
      endcase
   end

   always_comb begin
      capture = 1'b0;
      scnt_d  = scnt_q;
      case (state_q)
         ST_WAIT:   scnt_d = '0;
         ST_SETTLE: begin
            if (one_low && any_chg)          scnt_d = '0;
            else if (one_low && settled)     capture = 1'b1;
            else if (scnt_q != '1)           scnt_d = scnt_q + 1'b1;
         end
         default:   scnt_d = scnt_q;
      endcase
   end

   // Completion takes priority over a coincident timeout.
   assign complete    = (seen_q == 8'hFF);
   assign timeout_hit = !complete && (seen_q != 8'h00) && (tcnt_q == TW'(TIMEOUT_CYC - 1));

   always_comb begin
      seen_d    = seen_q;
      err_acc_d = err_acc_q;
      tcnt_d    = tcnt_q;
      if (capture) begin
         seen_d[dig_idx] = 1'b1;
         err_acc_d       = err_acc_q | dec_err;
      end
      if (complete || timeout_hit) begin
         seen_d    = '0;
         err_acc_d = 1'b0;
         tcnt_d    = '0;
      end else if (seen_q != 8'h00 && tcnt_q != '1) begin
         tcnt_d = tcnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         seen_q          <= '0;
         err_acc_q       <= 1'b0;
         tcnt_q          <= '0;
         slot_nib_q      <= '0;
         slot_blank_q    <= '0;
         slot_dp_q       <= '0;
         disp_data_q     <= '0;
         blank_mask_q    <= '0;
         dp_mask_q       <= '0;
         frame_valid_q   <= 1'b0;
         frame_err_q     <= 1'b0;
         frame_timeout_q <= 1'b0;
      end else begin
         seen_q          <= seen_d;
         err_acc_q       <= err_acc_d;
         tcnt_q          <= tcnt_d;
         frame_valid_q   <= complete;
         frame_timeout_q <= timeout_hit;
         if (capture) begin
            slot_nib_q[{dig_idx, 2'b00} +: 4] <= dec_nib;
            slot_blank_q[dig_idx]             <= dec_blank;
            slot_dp_q[dig_idx]                <= ~seg_q[7];
         end
         if (complete) begin
            disp_data_q  <= slot_nib_q;
            blank_mask_q <= slot_blank_q;
            dp_mask_q    <= slot_dp_q;
            frame_err_q  <= err_acc_q;
         end
      end
   end

   assign disp_data     = disp_data_q;
   assign blank_mask    = blank_mask_q;
   assign dp_mask       = dp_mask_q;
   assign frame_valid   = frame_valid_q;
   assign frame_err     = frame_err_q;
   assign frame_timeout = frame_timeout_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder: stimulus pushes expected frames,
// a monitor pops and compares on every frame_valid / frame_timeout pulse.
module tb_seg_scan_decoder;

   localparam int SETTLE = 16;
   localparam int TMO    = 4000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  sel = 8'hFF;
   logic [7:0]  seg = 8'hFF;
   logic [31:0] disp_data;
   logic [7:0]  blank_mask, dp_mask;
   logic        frame_valid, frame_err, frame_timeout;

   seg_scan_decoder #(.SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TMO)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .sel           (sel),
      .seg           (seg),
      .disp_data     (disp_data),
      .blank_mask    (blank_mask),
      .dp_mask       (dp_mask),
      .frame_valid   (frame_valid),
      .frame_err     (frame_err),
      .frame_timeout (frame_timeout)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] d;
      logic [7:0]  b;
      logic [7:0]  p;
      logic        e;
   } exp_t;

   exp_t        exp_q[$];
   int          exp_timeouts = 0;
   logic [31:0] last_good = 32'h0;
   int          checks = 0;
   int          errors = 0;

   function automatic logic [6:0] enc(input logic [3:0] n);
      case (n)
         4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
         4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
         4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
         4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, want %h", name, act, req);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push_frame(input logic [31:0] d, input logic [7:0] b, input logic [7:0] p, input logic e);
      exp_t x;
      x.d = d; x.b = b; x.p = p; x.e = e;
      exp_q.push_back(x);
   endtask

   task automatic show_digit(input int idx, input logic [6:0] pat, input logic dp);
      sel = ~(8'h01 << idx);
      seg = {~dp, ~pat};
      cyc(100);
      sel = 8'hFF;
      seg = 8'hFF;
      cyc(20);
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 0; i < 8; i++) show_digit(i, enc(w[4*i +: 4]), 1'b0);
   endtask

   // Monitor / scoreboard
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (frame_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL frame_unexpected: got frame %h, want none", disp_data);
            end else begin
               e = exp_q.pop_front();
               check("disp_data", disp_data, e.d);
               check("blank_mask", 32'(blank_mask), 32'(e.b));
               check("dp_mask", 32'(dp_mask), 32'(e.p));
               check("frame_err", 32'(frame_err), 32'(e.e));
               last_good = e.d;
            end
         end
         if (frame_timeout) begin
            checks++;
            if (exp_timeouts == 0) begin
               errors++;
               $display("FAIL timeout_unexpected: got pulse, want none");
            end else begin
               exp_timeouts--;
            end
            check("hold_after_timeout", disp_data, last_good);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish, want finish");
      $fatal(1);
   end

   initial begin
      int t;
      cyc(3);
      check("rst_disp_data", disp_data, 32'h0);
      check("rst_masks", {16'h0, blank_mask, dp_mask}, 32'h0);
      check("rst_flags", 32'({frame_valid, frame_err, frame_timeout}), 32'h0);
      rst_n = 1'b1;
      cyc(5);

      // Plain frame
      push_frame(32'h1234_ABCD, 8'h00, 8'h00, 1'b0);
      send_word(32'h1234_ABCD);

      // Bouncing digit 3 scanned last; latency from final change to frame_valid
      push_frame(32'h7654_8210, 8'h00, 8'h00, 1'b0);
      for (int i = 0; i < 8; i++)
         if (i != 3) show_digit(i, enc(4'(i)), 1'b0);
      sel = 8'b1111_0111;
      for (int k = 0; k < 9; k++) begin
         seg = {1'b1, ~((k % 2 == 0) ? 7'h06 : 7'h7F)};
         cyc(5);
      end
      seg = {1'b1, ~7'h7F};
      t = 0;
      while (!frame_valid && t < 100) begin
         cyc(1);
         t++;
      end
      // pin sample edge + SETTLE+1 to capture + 1 to frame_valid, seen half a cycle later
      check("capture_latency", 32'(t), 32'(SETTLE + 3));
      cyc(30);
      sel = 8'hFF; seg = 8'hFF;
      cyc(20);

      // Invalid pattern on digit 5, then a clean frame
      push_frame(32'h1204_ABCD, 8'h00, 8'h00, 1'b1);
      for (int i = 0; i < 8; i++)
         show_digit(i, (i == 5) ? 7'h49 : enc(4'(32'h1234_ABCD >> (4*i))), 1'b0);
      push_frame(32'hCAFE_0123, 8'h00, 8'h00, 1'b0);
      send_word(32'hCAFE_0123);

      // Partial frame then idle until timeout
      exp_timeouts = 1;
      for (int i = 0; i < 7; i++) show_digit(i, enc(4'(32'h0BAD_F00D >> (4*i))), 1'b0);
      t = 0;
      while (!frame_timeout && t < 5000) begin
         cyc(1);
         t++;
      end
      checks++;
      if (!frame_timeout) begin
         errors++;
         $display("FAIL timeout_wait: got no pulse in %0d cycles, want pulse", t);
      end
      cyc(5);
      push_frame(32'h89AB_CDEF, 8'h00, 8'h00, 1'b0);
      send_word(32'h89AB_CDEF);

      // Blank digit 2 with dp, plus a two-low sel glitch that must not capture
      push_frame(32'h7654_3010, 8'h04, 8'h04, 1'b0);
      show_digit(0, enc(4'h0), 1'b0);
      show_digit(1, enc(4'h1), 1'b0);
      show_digit(2, 7'h00, 1'b1);
      show_digit(3, enc(4'h3), 1'b0);
      sel = 8'b1111_0011;
      seg = {1'b1, ~enc(4'h1)};
      cyc(30);
      sel = 8'hFF; seg = 8'hFF;
      cyc(20);
      for (int i = 4; i < 8; i++) show_digit(i, enc(4'(i)), 1'b0);

      // Reset after four captures; a full fresh frame is then required
      for (int i = 0; i < 4; i++) show_digit(i, enc(4'h9), 1'b0);
      rst_n = 1'b0;
      cyc(1);
      check("mid_rst_disp_data", disp_data, 32'h0);
      check("mid_rst_masks", {16'h0, blank_mask, dp_mask}, 32'h0);
      check("mid_rst_flags", 32'({frame_valid, frame_err, frame_timeout}), 32'h0);
      rst_n = 1'b1;
      last_good = 32'h0;
      cyc(3);
      push_frame(32'hFEDC_3210, 8'h00, 8'h00, 1'b0);
      for (int i = 4; i < 8; i++) show_digit(i, enc(4'(32'hFEDC_3210 >> (4*i))), 1'b0);
      for (int i = 0; i < 4; i++) show_digit(i, enc(4'(i)), 1'b0);

      cyc(20);
      check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
      check("timeouts_pending", 32'(exp_timeouts), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
